routing_crossbar: RTL and testbench

Parametrised, registered successor to the single-output routing block: routes any of `NUM_INPUTS` data lanes to each of `NUM_OUTPUTS` output lanes. Each output has its own select, staged in a shadow register through a valid/ready configuration port and applied to all outputs atomically on commit. Sits in the fabric between tile outputs and downstream consumers and carries per-lane valid and per-output invalid-configuration flags.

---
 rtl/routing_pkg.sv | 21 ++
 rtl/routing_lane_mux.sv | 47 ++++
 rtl/routing_crossbar.sv | 137 +++++++++++++
 tb/tb_routing_crossbar.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/routing_pkg.sv
// Shared types, defaults and helpers for the routing crossbar.
package routing_pkg;

    localparam int unsigned DefNumInputs  = 8;
    localparam int unsigned DefNumOutputs = 4;
    localparam int unsigned DefDataWidth  = 32;
    localparam int unsigned DefSelWidth   = 4;
    localparam int unsigned DefPortWidth  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StStaged,
        StApply
    } cfg_state_e;

    // Bit offset of lane idx inside a packed lane vector.
    function automatic int unsigned lane_lsb(int unsigned idx, int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/routing_lane_mux.sv
// Registered NUM_INPUTS:1 lane mux for one crossbar output.
module routing_lane_mux
    import routing_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = DefNumInputs,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned SEL_WIDTH  = DefSelWidth
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] lanes_i,
    input  logic [NUM_INPUTS-1:0]          valid_i,
    input  logic [SEL_WIDTH-1:0]           sel_i,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic                           valid_o
);

    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  valid_d, valid_q;

    // Select decode; an out-of-range select matches no lane and yields zero/invalid.
    always_comb begin
        data_d  = '0;
        valid_d = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sel_i == SEL_WIDTH'(i)) begin
                data_d  = lanes_i[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
                valid_d = valid_i[i];
            end
        end
    end

    // Output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/routing_crossbar.sv
// Registered crossbar with shadowed per-output selects and atomic commit.
module routing_crossbar
    import routing_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = DefNumInputs,
    parameter int unsigned NUM_OUTPUTS = DefNumOutputs,
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned SEL_WIDTH   = DefSelWidth,
    parameter int unsigned PORT_WIDTH  = DefPortWidth
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] inputState,
    input  logic [NUM_INPUTS-1:0]            inValid,
    input  logic                             cfgValid,
    output logic                             cfgReady,
    input  logic [PORT_WIDTH-1:0]            cfgPort,
    input  logic [SEL_WIDTH-1:0]             cfgSel,
    input  logic                             cfgCommit,
    input  logic                             cfgErrClr,
    output logic                             cfgErr,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out,
    output logic [NUM_OUTPUTS-1:0]           outValid,
    output logic [NUM_OUTPUTS-1:0]           configInvalid
);

    cfg_state_e           state_q;
    logic                 ready_q;
    logic                 err_q;
    logic [SEL_WIDTH-1:0] shadow_d [NUM_OUTPUTS];
    logic [SEL_WIDTH-1:0] shadow_q [NUM_OUTPUTS];
    logic [SEL_WIDTH-1:0] active_q [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] inv_q;

    logic wr_accept;
    logic port_ok;

    assign wr_accept = cfgValid && ready_q;
    assign port_ok   = 32'(cfgPort) < NUM_OUTPUTS;

    // Shadow next-state: an accepted in-range write updates exactly one entry.
    always_comb begin
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            shadow_d[o] = shadow_q[o];
            if (wr_accept && (cfgPort == PORT_WIDTH'(o))) begin
                shadow_d[o] = cfgSel;
            end
        end
    end

    // Shadow select storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_OUTPUTS; o++) shadow_q[o] <= '0;
        end else begin
            for (int o = 0; o < NUM_OUTPUTS; o++) shadow_q[o] <= shadow_d[o];
        end
    end

    // Config FSM with registered ready; commits during APPLY are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfgCommit) begin
                        state_q <= StApply;
                        ready_q <= 1'b0;
                    end else if (wr_accept) begin
                        state_q <= StStaged;
                    end
                end
                StStaged: begin
                    if (cfgCommit) begin
                        state_q <= StApply;
                        ready_q <= 1'b0;
                    end
                end
                StApply: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Active selects and invalid flags move together in the APPLY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_OUTPUTS; o++) active_q[o] <= '0;
            inv_q <= '0;
        end else if (state_q == StApply) begin
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                active_q[o] <= shadow_q[o];
                inv_q[o]    <= 32'(shadow_q[o]) >= NUM_INPUTS;
            end
        end
    end

    // Sticky error on out-of-range port writes; a new error beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (wr_accept && !port_ok) begin
            err_q <= 1'b1;
        end else if (cfgErrClr) begin
            err_q <= 1'b0;
        end
    end

    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_lane
        routing_lane_mux #(
            .NUM_INPUTS (NUM_INPUTS),
            .DATA_WIDTH (DATA_WIDTH),
            .SEL_WIDTH  (SEL_WIDTH)
        ) u_mux (
            .clk     (clk),
            .rst     (rst),
            .lanes_i (inputState),
            .valid_i (inValid),
            .sel_i   (active_q[o]),
            .data_o  (out[o*DATA_WIDTH +: DATA_WIDTH]),
            .valid_o (outValid[o])
        );
    end

    assign cfgReady      = ready_q;
    assign cfgErr        = err_q;
    assign configInvalid = inv_q;

endmodule

// File: tb/tb_routing_crossbar.sv
// Directed self-checking bench for routing_crossbar.
module tb_routing_crossbar;

    localparam int unsigned NI = 8;
    localparam int unsigned NO = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned PW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [NI*DW-1:0] inputState;
    logic [NI-1:0]    inValid;
    logic             cfgValid;
    logic             cfgReady;
    logic [PW-1:0]    cfgPort;
    logic [SW-1:0]    cfgSel;
    logic             cfgCommit;
    logic             cfgErrClr;
    logic             cfgErr;
    logic [NO*DW-1:0] out;
    logic [NO-1:0]    outValid;
    logic [NO-1:0]    configInvalid;

    int errors = 0;
    int checks = 0;

    routing_crossbar #(
        .NUM_INPUTS  (NI),
        .NUM_OUTPUTS (NO),
        .DATA_WIDTH  (DW),
        .SEL_WIDTH   (SW),
        .PORT_WIDTH  (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inputState    (inputState),
        .inValid       (inValid),
        .cfgValid      (cfgValid),
        .cfgReady      (cfgReady),
        .cfgPort       (cfgPort),
        .cfgSel        (cfgSel),
        .cfgCommit     (cfgCommit),
        .cfgErrClr     (cfgErrClr),
        .cfgErr        (cfgErr),
        .out           (out),
        .outValid      (outValid),
        .configInvalid (configInvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [PW-1:0] port, input logic [SW-1:0] sel);
        cfgValid = 1'b1;
        cfgPort  = port;
        cfgSel   = sel;
        step();
        cfgValid = 1'b0;
    endtask

    localparam logic [127:0] AllLane0 = {32'h1000_0000, 32'h1000_0000,
                                         32'h1000_0000, 32'h1000_0000};
    localparam logic [127:0] Route1   = {32'h1000_0000, 32'h1000_0003,
                                         32'h1000_0003, 32'h1000_0007};
    localparam logic [127:0] Route2   = {32'h1000_0000, 32'h0000_0000,
                                         32'h1000_0003, 32'h1000_0007};
    localparam logic [127:0] Route3   = {32'h1000_0000, 32'h0000_0000,
                                         32'h1000_0006, 32'h1000_0007};

    initial begin
        rst        = 1'b1;
        inputState = '0;
        inValid    = '0;
        cfgValid   = 1'b0;
        cfgPort    = '0;
        cfgSel     = '0;
        cfgCommit  = 1'b0;
        cfgErrClr  = 1'b0;
        step();
        step();

        // Reset state
        check("rst_out", 128'(out), 128'h0);
        check("rst_outValid", 128'(outValid), 128'h0);
        check("rst_cfgInvalid", 128'(configInvalid), 128'h0);
        check("rst_cfgErr", 128'(cfgErr), 128'h0);
        check("rst_cfgReady", 128'(cfgReady), 128'h1);

        rst = 1'b0;
        for (int i = 0; i < NI; i++) inputState[i*DW +: DW] = 32'h1000_0000 + 32'(i);
        inValid = 8'hFF;
        step();
        check("sel0_out", 128'(out), AllLane0);
        check("sel0_outValid", 128'(outValid), 128'hF);
        check("sel0_cfgInvalid", 128'(configInvalid), 128'h0);

        // Program 7/3/3/0 and commit
        cfg_write(3'd0, 4'd7);
        cfg_write(3'd1, 4'd3);
        cfg_write(3'd2, 4'd3);
        cfg_write(3'd3, 4'd0);
        check("staged_ready", 128'(cfgReady), 128'h1);
        check("staged_out_old", 128'(out), AllLane0);
        cfgCommit = 1'b1;
        step();                                   // E0
        cfgCommit = 1'b0;
        check("apply_ready_low", 128'(cfgReady), 128'h0);
        check("apply_out_old", 128'(out), AllLane0);
        step();                                   // E1
        check("e1_ready_high", 128'(cfgReady), 128'h1);
        check("e1_out_old", 128'(out), AllLane0);
        step();                                   // E2
        check("route1_out", 128'(out), Route1);
        check("route1_outValid", 128'(outValid), 128'hF);

        // Invalid select on port 2
        cfg_write(3'd2, 4'd9);
        cfgCommit = 1'b1;
        step();
        cfgCommit = 1'b0;
        step();
        check("inv_flag", 128'(configInvalid), 128'h4);
        step();
        check("inv_out", 128'(out), Route2);
        check("inv_outValid", 128'(outValid), 128'hB);

        // Out-of-range port write
        cfg_write(3'd5, 4'd1);
        check("err_set", 128'(cfgErr), 128'h1);
        cfgErrClr = 1'b1;
        step();
        cfgErrClr = 1'b0;
        check("err_clr", 128'(cfgErr), 128'h0);
        cfgErrClr = 1'b1;
        cfg_write(3'd4, 4'd1);
        cfgErrClr = 1'b0;
        check("err_set_wins", 128'(cfgErr), 128'h1);
        cfgErrClr = 1'b1;
        step();
        cfgErrClr = 1'b0;
        check("err_clr2", 128'(cfgErr), 128'h0);

        // Re-apply: shadow must not have been touched by the bad writes
        cfgCommit = 1'b1;
        step();
        cfgCommit = 1'b0;
        step();
        step();
        check("reapply_out", 128'(out), Route2);
        check("reapply_inv", 128'(configInvalid), 128'h4);

        // Write + commit same cycle, then a commit during APPLY
        cfgValid  = 1'b1;
        cfgPort   = 3'd1;
        cfgSel    = 4'd6;
        cfgCommit = 1'b1;
        step();                                   // E0
        cfgValid  = 1'b0;
        check("wc_ready_low", 128'(cfgReady), 128'h0);
        step();                                   // E1, commit held high in APPLY
        cfgCommit = 1'b0;
        check("wc_ignore_commit", 128'(cfgReady), 128'h1);
        step();                                   // E2
        check("wc_out", 128'(out), Route3);
        check("wc_outValid", 128'(outValid), 128'hB);
        check("wc_ready_stays", 128'(cfgReady), 128'h1);
        inValid = 8'hBF;
        step();
        check("lane6_invalid", 128'(outValid), 128'h9);
        check("lane6_out_data", 128'(out), Route3);

        // Reset asserted during APPLY
        cfg_write(3'd0, 4'd2);
        cfgCommit = 1'b1;
        step();
        cfgCommit = 1'b0;
        check("pre_rst_ready", 128'(cfgReady), 128'h0);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out", 128'(out), 128'h0);
        check("midrst_outValid", 128'(outValid), 128'h0);
        check("midrst_cfgInvalid", 128'(configInvalid), 128'h0);
        check("midrst_ready", 128'(cfgReady), 128'h1);
        step();
        rst = 1'b0;
        step();
        check("postrst_out", 128'(out), AllLane0);
        check("postrst_outValid", 128'(outValid), 128'hF);
        cfgCommit = 1'b1;
        step();
        cfgCommit = 1'b0;
        step();
        step();
        check("postrst_reapply_out", 128'(out), AllLane0);
        check("postrst_reapply_inv", 128'(configInvalid), 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
